benes_net_pipe: RTL

- Parametrised, fully pipelined N-port Benes permutation network. It generalises the fixed 8-port / 4-bit / 5-stage network to any power-of-two port count and any data width.
- Adds valid tracking and double-buffered switch configuration. A committed configuration is applied as a wavefront that follows the data, so in-flight beats are never routed with a mix of old and new settings.
- Sits between the ingress port array and the egress buffers of the switching fabric.

---
 rtl/benes_pkg.sv | 31 +++
 rtl/benes_net_pipe_stage.sv | 39 +++
 rtl/benes_net_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/benes_pkg.sv
// Shared constants and stage-link position map for the pipelined Benes network.
package benes_pkg;

    localparam logic SW_BAR   = 1'b0;
    localparam logic SW_CROSS = 1'b1;

    // Destination position of position j on the link after stage s of an n-port network.
    function automatic int unsigned link_dst(input int unsigned n, input int unsigned s,
                                             input int unsigned j);
        int unsigned l;
        int unsigned stg;
        int unsigned blk;
        int unsigned base;
        int unsigned r;
        logic        shuf;
        l = $clog2(n);
        if (s + 2 <= l) begin
            stg  = s;
            shuf = 1'b0;
        end else begin
            stg  = 2 * l - 3 - s;
            shuf = 1'b1;
        end
        blk  = n >> stg;
        base = (j / blk) * blk;
        r    = j % blk;
        if (!shuf) return base + (((r % 2) == 0) ? (r / 2) : (blk / 2 + r / 2));
        return base + ((r < blk / 2) ? (2 * r) : (2 * (r - blk / 2) + 1));
    endfunction

endpackage

// File: rtl/benes_net_pipe_stage.sv
// One registered column of 2x2 switches; valid travels alongside the data.
module benes_stage
    import benes_pkg::*;
#(
    parameter int unsigned N_PORTS = 8,
    parameter int unsigned DATA_W  = 4,
    localparam int unsigned N_SW   = N_PORTS / 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [N_PORTS*DATA_W-1:0] in_data,
    input  logic [N_SW-1:0]           sel,
    output logic                      out_valid,
    output logic [N_PORTS*DATA_W-1:0] out_data
);

    logic [N_PORTS*DATA_W-1:0] sw_data;

    for (genvar k = 0; k < int'(N_SW); k++) begin : g_sw
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        assign a = in_data[(2*k)*DATA_W +: DATA_W];
        assign b = in_data[(2*k+1)*DATA_W +: DATA_W];
        assign sw_data[(2*k)*DATA_W +: DATA_W]   = (sel[k] == SW_CROSS) ? b : a;
        assign sw_data[(2*k+1)*DATA_W +: DATA_W] = (sel[k] == SW_CROSS) ? a : b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            out_data  <= sw_data;
        end
    end

endmodule

// File: rtl/benes_net_pipe.sv
// Pipelined N-port Benes network with double-buffered config applied as a wavefront.
// Optional config readback port enabled by BENES_CFG_READBACK_EN.
module benes_net_pipe
    import benes_pkg::*;
#(
    parameter int unsigned N_PORTS   = 8,
    parameter int unsigned DATA_W    = 4,
    localparam int unsigned LOG2N    = $clog2(N_PORTS),
    localparam int unsigned N_STAGES = 2 * LOG2N - 1,
    localparam int unsigned N_SW     = N_PORTS / 2,
    localparam int unsigned STG_W    = $clog2(N_STAGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [N_PORTS*DATA_W-1:0] i_port,
    output logic                      o_valid,
    output logic [N_PORTS*DATA_W-1:0] o_port,
    input  logic                      cfg_wr_en,
    input  logic [STG_W-1:0]          cfg_wr_stage,
    input  logic [N_SW-1:0]           cfg_wr_data,
    input  logic                      cfg_commit,
    output logic                      cfg_busy,
    output logic                      cfg_err
`ifdef BENES_CFG_READBACK_EN
    ,
    input  logic [STG_W-1:0]          cfg_rd_stage,
    output logic [N_SW-1:0]           cfg_rd_data
`endif
);

    logic [N_SW-1:0]           shadow [N_STAGES];
    logic [N_SW-1:0]           snap   [N_STAGES];
    logic [N_SW-1:0]           active [N_STAGES];
    logic [STG_W-1:0]          wave;
    logic [N_PORTS*DATA_W-1:0] st_in  [N_STAGES];
    logic [N_PORTS*DATA_W-1:0] st_out [N_STAGES];
    logic [N_STAGES-1:0]       v_in;
    logic [N_STAGES-1:0]       v_out;

    assign st_in[0] = i_port;
    assign v_in[0]  = i_valid;

    for (genvar s = 0; s < int'(N_STAGES); s++) begin : g_stage
        benes_stage #(.N_PORTS(N_PORTS), .DATA_W(DATA_W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_valid (v_in[s]),
            .in_data  (st_in[s]),
            .sel      (active[s]),
            .out_valid(v_out[s]),
            .out_data (st_out[s])
        );
        if (s < int'(N_STAGES) - 1) begin : g_link
            assign v_in[s+1] = v_out[s];
            for (genvar j = 0; j < int'(N_PORTS); j++) begin : g_pos
                localparam int unsigned DST = link_dst(N_PORTS, s, j);
                assign st_in[s+1][DST*DATA_W +: DATA_W] = st_out[s][j*DATA_W +: DATA_W];
            end
        end
    end

    assign o_valid = v_out[N_STAGES-1];
    assign o_port  = st_out[N_STAGES-1];

    // Commit snapshots shadow and loads active[0]; active[s] follows s cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '{default: '0};
            snap     <= '{default: '0};
            active   <= '{default: '0};
            wave     <= '0;
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (cfg_wr_en && (32'(cfg_wr_stage) < N_STAGES)) begin
                shadow[cfg_wr_stage] <= cfg_wr_data;
            end
            if (cfg_commit) begin
                if (cfg_busy) begin
                    cfg_err <= 1'b1;
                end else begin
                    snap      <= shadow;
                    active[0] <= shadow[0];
                    cfg_busy  <= 1'b1;
                    wave      <= STG_W'(1);
                end
            end
            if (cfg_busy) begin
                active[wave] <= snap[wave];
                if (32'(wave) == N_STAGES - 1) begin
                    cfg_busy <= 1'b0;
                    wave     <= '0;
                end else begin
                    wave <= wave + STG_W'(1);
                end
            end
        end
    end

`ifdef BENES_CFG_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rd_data <= '0;
        end else if (32'(cfg_rd_stage) < N_STAGES) begin
            cfg_rd_data <= active[cfg_rd_stage];
        end else begin
            cfg_rd_data <= '0;
        end
    end
`endif

endmodule
